// File: rtl/sobel_stream_pkg.sv
// Shared widths, pipeline tag type and arithmetic helpers for the streaming
// Sobel edge detector.
package sobel_stream_pkg;

    localparam int PIX_W   = 8;
    localparam int GRAD_W  = 11;
    localparam int MAG_W   = 12;
    localparam int MAG_MAX = 255;
    localparam int RGB_W   = 6;

    typedef struct packed {
        logic valid;
        logic mask;
    } stage_tag_t;

    function automatic logic signed [GRAD_W-1:0] ext_pix(input logic [PIX_W-1:0] p);
        return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        logic [GRAD_W-1:0] res;
        if (g[GRAD_W-1]) begin
            res = GRAD_W'(-g);
        end else begin
            res = GRAD_W'(g);
        end
        return res;
    endfunction

    function automatic logic [PIX_W-1:0] sat_mag(input logic [MAG_W-1:0] m);
        logic [PIX_W-1:0] res;
        if (m > MAG_W'(MAG_MAX)) begin
            res = PIX_W'(MAG_MAX);
        end else begin
            res = m[PIX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/sobel_stream_line_buffer.sv
// One raster line of pixel storage: single write port, single registered read
// port; a read and write to the same address returns the old contents.
module sobel_stream_line_buffer
    import sobel_stream_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem_r [DEPTH];
    logic [PIX_W-1:0] rd_data_r;

    // Storage array and registered read; contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: raster counters, two line buffers, a 3x3
// window and a three-stage gradient pipeline, one pixel per clock.
module sobel_stream
    import sobel_stream_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10,
    parameter int RW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_in,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_mag,
    output logic [RGB_W-1:0] out_rgb
);

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [CW-1:0] eff_col_s;
    logic [RW-1:0] eff_row_s;

    logic [PIX_W-1:0] p00_r, p01_r, p02_s;
    logic [PIX_W-1:0] p10_r, p11_r, p12_s;
    logic [PIX_W-1:0] p20_r, p21_r, p22_r;

    logic          lb1_wr_en_r;
    logic [CW-1:0] lb1_wr_addr_r;

    stage_tag_t s1_tag_r, s2_tag_r, s3_tag_r;
    logic signed [GRAD_W-1:0] gx_s, gy_s, gx_r, gy_r;
    logic [MAG_W-1:0]         mag_r;
    logic [PIX_W-1:0]         res_s;

    // Position of the current pixel; a start-of-frame strobe resyncs to (0,0).
    always_comb begin
        eff_col_s = col_r;
        eff_row_s = row_r;
        if (pix_valid && pix_sof) begin
            eff_col_s = {CW{1'b0}};
            eff_row_s = {RW{1'b0}};
        end else begin
            eff_col_s = col_r;
            eff_row_s = row_r;
        end
    end

    // Raster counters holding the position of the next accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (pix_valid) begin
            if (eff_col_s == CW'(IMG_W - 1)) begin
                col_r <= {CW{1'b0}};
                if (eff_row_s == RW'(IMG_H - 1)) begin
                    row_r <= {RW{1'b0}};
                end else begin
                    row_r <= eff_row_s + RW'(1);
                end
            end else begin
                col_r <= eff_col_s + CW'(1);
                row_r <= eff_row_s;
            end
        end
    end

    // The registered read ports form the newest window column (rows 0 and 1).
    sobel_stream_line_buffer #(.DEPTH(IMG_W), .AW(CW)) lb0 (
        .clk     (clk),
        .rd_en   (pix_valid),
        .rd_addr (eff_col_s),
        .wr_en   (pix_valid),
        .wr_addr (eff_col_s),
        .wr_data (pix_in),
        .rd_data (p12_s)
    );

    sobel_stream_line_buffer #(.DEPTH(IMG_W), .AW(CW)) lb1 (
        .clk     (clk),
        .rd_en   (pix_valid),
        .rd_addr (eff_col_s),
        .wr_en   (lb1_wr_en_r),
        .wr_addr (lb1_wr_addr_r),
        .wr_data (p12_s),
        .rd_data (p02_s)
    );

    // lb1 takes lb0's old value one clock later, once lb0's read has landed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lb1_wr_en_r   <= 1'b0;
            lb1_wr_addr_r <= {CW{1'b0}};
        end else begin
            lb1_wr_en_r   <= pix_valid;
            lb1_wr_addr_r <= eff_col_s;
        end
    end

    // Window shift on each accepted pixel; gaps leave the window untouched.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            p22_r <= pix_in;
            p21_r <= p22_r;
            p20_r <= p21_r;
            p11_r <= p12_s;
            p10_r <= p11_r;
            p01_r <= p02_s;
            p00_r <= p01_r;
        end
    end

    // Gradient kernels over the current window.
    always_comb begin
        gx_s = (ext_pix(p02_s) + ext_pix(p12_s) + ext_pix(p12_s) + ext_pix(p22_r))
             - (ext_pix(p00_r) + ext_pix(p10_r) + ext_pix(p10_r) + ext_pix(p20_r));
        gy_s = (ext_pix(p20_r) + ext_pix(p21_r) + ext_pix(p21_r) + ext_pix(p22_r))
             - (ext_pix(p00_r) + ext_pix(p01_r) + ext_pix(p01_r) + ext_pix(p02_s));
    end

    // Arithmetic stages advance only alongside a valid tag.
    always_ff @(posedge clk) begin
        if (s1_tag_r.valid) begin
            gx_r <= gx_s;
            gy_r <= gy_s;
        end
        if (s2_tag_r.valid) begin
            mag_r <= {1'b0, abs_grad(gx_r)} + {1'b0, abs_grad(gy_r)};
        end
    end

    // Valid/border tags; the border mask rides with each pixel to the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_tag_r <= '{valid: 1'b0, mask: 1'b0};
            s2_tag_r <= '{valid: 1'b0, mask: 1'b0};
            s3_tag_r <= '{valid: 1'b0, mask: 1'b0};
        end else begin
            s1_tag_r.valid <= pix_valid;
            s1_tag_r.mask  <= (eff_row_s < RW'(2)) || (eff_col_s < CW'(2));
            s2_tag_r       <= s1_tag_r;
            s3_tag_r       <= s2_tag_r;
        end
    end

    // Saturation with the border rule applied last.
    always_comb begin
        res_s = sat_mag(mag_r);
        if (s3_tag_r.mask) begin
            res_s = 8'd0;
        end else begin
            res_s = sat_mag(mag_r);
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mag   <= 8'd0;
            out_rgb   <= 6'd0;
        end else begin
            out_valid <= s3_tag_r.valid;
            if (s3_tag_r.valid) begin
                out_mag <= res_s;
                out_rgb <= {res_s[7:6], res_s[7:6], res_s[7:6]};
            end else begin
                out_mag <= out_mag;
                out_rgb <= out_rgb;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on a 16x8 raster: directed frames with
// hand-derived expected magnitudes and exact 3-clock output latency.
module tb_sobel_stream;

    localparam int W = 16;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid;
    logic       pix_sof;
    logic [7:0] pix_in;
    logic       out_valid;
    logic [7:0] out_mag;
    logic [5:0] out_rgb;

    always #5 clk = ~clk;

    sobel_stream #(.IMG_W(W), .IMG_H(H), .CW(10), .RW(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_in    (pix_in),
        .out_valid (out_valid),
        .out_mag   (out_mag),
        .out_rgb   (out_rgb)
    );

    typedef struct {
        logic [7:0] mag;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   r_m = 0;
    int   c_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pattern 0: uniform 100, 1: ramp 16*col, 2: vertical step 0|255 at col 8.
    function automatic logic [7:0] pix_of(input int pat, input int c);
        case (pat)
            0:       return 8'd100;
            1:       return 8'(16 * c);
            default: return (c < 8) ? 8'd0 : 8'd255;
        endcase
    endfunction

    function automatic logic [7:0] exp_of(input int pat, input int r, input int c);
        if (r < 2 || c < 2) return 8'd0;
        case (pat)
            0:       return 8'd0;
            1:       return 8'd128;
            default: return (c == 8 || c == 9) ? 8'd255 : 8'd0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int pat, input bit sof);
        if (sof) begin
            r_m = 0;
            c_m = 0;
        end
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_in    = pix_of(pat, c_m);
        q.push_back('{mag: exp_of(pat, r_m, c_m), due: cyc + 4});
        c_m++;
        if (c_m == W) begin
            c_m = 0;
            r_m = (r_m == H - 1) ? 0 : r_m + 1;
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic frame(input int pat, input int n, input bit gaps, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle();
            send(pat, sof_first && (i == 0));
        end
    endtask

    // Monitor: every presented output is matched against the queue head,
    // including the cycle it was due; an overdue entry is a missing output.
    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got mag=%0d at cycle %0d, expected no output", out_mag, cyc);
            end else begin
                mon_e = q.pop_front();
                if (out_mag !== mon_e.mag || out_rgb !== {mon_e.mag[7:6], mon_e.mag[7:6], mon_e.mag[7:6]}
                    || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL out_check: got mag=%0d rgb=%b cycle=%0d, expected mag=%0d rgb=%b cycle=%0d",
                             out_mag, out_rgb, cyc, mon_e.mag,
                             {mon_e.mag[7:6], mon_e.mag[7:6], mon_e.mag[7:6]}, mon_e.due);
                end
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            checks++;
            errors++;
            mon_e = q.pop_front();
            $display("FAIL missing_out: no output at cycle %0d, expected mag=%0d due at cycle %0d",
                     cyc, mon_e.mag, mon_e.due);
        end
    end

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_in    = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_mag", int'(out_mag), 0);
        chk("reset_out_rgb", int'(out_rgb), 0);
        rst = 1'b0;
        idle();

        frame(0, W * H, 1'b0, 1'b1);
        frame(1, W * H, 1'b0, 1'b1);
        frame(2, W * H, 1'b0, 1'b1);
        frame(1, W * H, 1'b1, 1'b1);

        // Reset while pixel (4,5) would be presented: in-flight results vanish.
        frame(1, 4 * W + 5, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        chk("out_valid_after_rst", int'(out_valid), 0);
        chk("out_mag_after_rst", int'(out_mag), 0);
        frame(1, W * H, 1'b0, 1'b1);
        frame(0, W * H, 1'b1, 1'b1);

        // Start-of-frame at (3,7) restarts the raster at that pixel.
        frame(1, 3 * W + 7, 1'b0, 1'b1);
        frame(1, W * H, 1'b0, 1'b1);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_out_valid", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
